// File: rtl/fifo_rr_scheduler.sv
// Round-robin mover from 4 source FIFOs to 4 destination FIFOs, routed by the word's top 2 bits.
// Pop to push takes 2 cycles; pause stalls new grants but lets in-flight words finish.
module fifo_rr_scheduler #(
  parameter int DATA_WIDTH = 6,
  parameter int N_SRC      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_SRC-1:0]            src_empty,
  input  logic [N_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [N_SRC-1:0]            dst_pausa,
  output logic [N_SRC-1:0]            src_pop,
  output logic [N_SRC-1:0]            dst_push,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic [1:0]                  state,
  output logic                        busy
);

  localparam int IW = $clog2(N_SRC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                  state_q;
  logic   [1:0]            cooldown [N_SRC];
  logic   [IW-1:0]         last_grant;
  logic                    s1_vld;
  logic   [IW-1:0]         s1_idx;
  logic                    s2_vld;
  logic   [IW-1:0]         s2_idx;
  logic   [N_SRC-1:0]      eligible;
  logic                    grant_vld;
  logic   [IW-1:0]         grant_idx;
  logic   [IW-1:0]         cand;
  logic   [DATA_WIDTH-1:0] word;

  assign state = state_q;

  // Search begins one past the last winner; the final candidate is last_grant itself.
  always_comb begin
    eligible  = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < N_SRC; i++) begin
      eligible[i] = !src_empty[i] && (cooldown[i] == 2'd0);
    end
    for (int k = 1; k <= N_SRC; k++) begin
      cand = last_grant + IW'(k);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    word = src_data[s2_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      src_pop    <= '0;
      dst_push   <= '0;
      data_out   <= '0;
      busy       <= 1'b0;
      last_grant <= IW'(N_SRC - 1);
      s1_vld     <= 1'b0;
      s1_idx     <= '0;
      s2_vld     <= 1'b0;
      s2_idx     <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        cooldown[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (cooldown[i] != 2'd0) cooldown[i] <= cooldown[i] - 2'd1;
      end
      src_pop <= '0;
      s1_vld  <= 1'b0;
      if (|dst_pausa) begin
        state_q <= HOLD;
      end else if (grant_vld) begin
        state_q               <= RUN;
        src_pop               <= N_SRC'(1) << grant_idx;
        s1_vld                <= 1'b1;
        s1_idx                <= grant_idx;
        last_grant            <= grant_idx;
        // Covers the source's 2-cycle empty-flag lag after a pop.
        cooldown[grant_idx]   <= 2'd2;
      end else begin
        state_q <= IDLE;
      end
      s2_vld   <= s1_vld;
      s2_idx   <= s1_idx;
      dst_push <= '0;
      if (s2_vld) begin
        data_out <= word;
        dst_push <= N_SRC'(1) << word[DATA_WIDTH-1 -: 2];
      end
      busy <= (!(|dst_pausa) && grant_vld) || s1_vld;
    end
  end

endmodule
